// File: rtl/pll_reset_seq.sv
// pll_reset_seq: turns the asynchronous PLL LOCK signal into a sequenced,
// active-low core reset. LOCK is synchronized, required to stay high for
// STABLE_CYCLES, then reset is held for HOLD_CYCLES more before release.
// Lock loss while running re-asserts reset and is recorded in lost/loss_cnt.
// Optional watchdog (macro PLL_RESET_SEQ_WATCHDOG_EN) pulses pll_rst when no
// qualified lock is seen for TIMEOUT_CYCLES cycles.
// ready follows sys_rst_n: both are low during reset and high only in RUN.
module pll_reset_seq #(
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int PLL_RST_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       clear_lost,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       lost,
    output logic [7:0] loss_cnt,
    output logic       pll_rst
);

    // Shared counter covers STABLE, HOLD and PLL_RST phases; it never exceeds max-1.
    localparam int CNT_MAX_SH = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_SH > PLL_RST_CYCLES) ? CNT_MAX_SH : PLL_RST_CYCLES;
    localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] STABLE    = 3'd1;
    localparam logic [2:0] HOLD      = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    localparam logic [2:0] PLL_RST   = 3'd4;
    localparam int WDW = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;
`endif

    // All cycle counts must be at least one for the sequencing to make sense.
    if (STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 || PLL_RST_CYCLES < 1) begin : g_bad_params
        $error("pll_reset_seq: all cycle parameters must be >= 1");
    end

    logic          sync1_reg;
    logic          lock_s;
    logic [2:0]    state_reg;
    logic [2:0]    state_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          sys_rst_n_reg;
    logic          lost_reg;
    logic [7:0]    loss_cnt_reg;
    logic          loss_event;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    logic [WDW-1:0] wd_reg;
    logic [WDW-1:0] wd_next;
    logic           pll_rst_reg;
`endif

    // Two-flop synchronizer for the asynchronous LOCK input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            sync1_reg <= locked;
            lock_s    <= sync1_reg;
        end
    end

    // Next-state logic; a lock drop anywhere before RUN simply restarts qualification.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            WAIT_LOCK: begin
                cnt_next = '0;
                if (lock_s) state_next = STABLE;
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == CW'(STABLE_CYCLES - 1)) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == CW'(HOLD_CYCLES - 1)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!lock_s) state_next = WAIT_LOCK;
            end
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
            PLL_RST: begin
                // lock_s is deliberately ignored while the PLL is being reset.
                if (cnt_reg == CW'(PLL_RST_CYCLES - 1)) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`endif
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        // Watchdog runs only while lock is not yet qualified and overrides the FSM on expiry.
        wd_next = '0;
        if (state_reg == WAIT_LOCK || state_reg == STABLE) begin
            if (wd_reg == WDW'(TIMEOUT_CYCLES - 1)) begin
                state_next = PLL_RST;
                cnt_next   = '0;
            end else if (state_next != HOLD) begin
                wd_next = wd_reg + 1'b1;
            end
        end
`endif
    end

    assign loss_event = (state_reg == RUN) && !lock_s;

    // State, counters and registered reset outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= WAIT_LOCK;
            cnt_reg       <= '0;
            sys_rst_n_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sys_rst_n_reg <= (state_next == RUN);
        end
    end

    // Loss bookkeeping; a loss in the same cycle as clear_lost counts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_reg     <= 1'b0;
            loss_cnt_reg <= 8'd0;
        end else if (loss_event) begin
            lost_reg <= 1'b1;
            if (clear_lost)
                loss_cnt_reg <= 8'd1;
            else if (loss_cnt_reg != 8'hFF)
                loss_cnt_reg <= loss_cnt_reg + 8'd1;
        end else if (clear_lost) begin
            lost_reg     <= 1'b0;
            loss_cnt_reg <= 8'd0;
        end
    end

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    // Watchdog counter and registered PLL reset request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_reg      <= '0;
            pll_rst_reg <= 1'b0;
        end else begin
            wd_reg      <= wd_next;
            pll_rst_reg <= (state_next == PLL_RST);
        end
    end
    assign pll_rst = pll_rst_reg;
`else
    assign pll_rst = 1'b0;
`endif

    assign sys_rst_n = sys_rst_n_reg;
    assign ready     = sys_rst_n_reg;
    assign lost      = lost_reg;
    assign loss_cnt  = loss_cnt_reg;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed testbench for pll_reset_seq with STABLE=4, HOLD=3, TIMEOUT=20,
// PLL_RST=5. Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, i.e. away from the active edge.
module tb_pll_reset_seq;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic       clear_lost;
    logic       sys_rst_n;
    logic       ready;
    logic       lost;
    logic [7:0] loss_cnt;
    logic       pll_rst;

    int errors = 0;
    int checks = 0;

    pll_reset_seq #(
        .STABLE_CYCLES  (4),
        .HOLD_CYCLES    (3),
        .TIMEOUT_CYCLES (20),
        .PLL_RST_CYCLES (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .locked     (locked),
        .clear_lost (clear_lost),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .lost       (lost),
        .loss_cnt   (loss_cnt),
        .pll_rst    (pll_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-16s observed=%0h expected=%0h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drop LOCK from RUN; the FSM leaves RUN two edges after the sampling edge.
    task automatic lose();
        locked = 1'b0;
        repeat (3) tick();
    endtask

    // Raise LOCK from WAIT_LOCK with empty sync flops; RUN after 10 edges.
    task automatic relock();
        locked = 1'b1;
        repeat (10) tick();
    endtask

    logic exp_pll;

    initial begin
        rst_n      = 1'b0;
        locked     = 1'b1;
        clear_lost = 1'b0;
        tick();
        tick();
        check("rst_sys_rst_n", sys_rst_n, 0);
        check("rst_ready",     ready,     0);
        check("rst_lost",      lost,      0);
        check("rst_loss_cnt",  loss_cnt,  0);
        check("rst_pll_rst",   pll_rst,   0);

        // 1: power-up, locked high from edge 0 -> release after edge 9
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("t1_pre_sys", sys_rst_n, 0);
        end
        tick();
        check("t1_run_sys",   sys_rst_n, 1);
        check("t1_run_ready", ready,     1);

        // 2: glitch; high at edges 0-2, low at 3, high from 4 -> RUN after edge 13
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("t2_pre_sys", sys_rst_n, 0);
        end
        tick();
        check("t2_run_sys",  sys_rst_n, 1);
        check("t2_lost",     lost,      0);
        check("t2_loss_cnt", loss_cnt,  0);

        // 3: loss in RUN, reset re-asserted after edge j+2
        locked = 1'b0;
        tick();
        check("t3_j0_sys", sys_rst_n, 1);
        tick();
        check("t3_j1_sys", sys_rst_n, 1);
        tick();
        check("t3_j2_sys",  sys_rst_n, 0);
        check("t3_lost",    lost,      1);
        check("t3_cnt",     loss_cnt,  1);
        locked = 1'b1;
        repeat (9) tick();
        check("t3_relock_pre", sys_rst_n, 0);
        tick();
        check("t3_relock_run", sys_rst_n, 1);
        check("t3_lost_stay",  lost,      1);

        // 4: lone clear, saturation, clear colliding with a loss, lone clear again
        clear_lost = 1'b1;
        tick();
        clear_lost = 1'b0;
        check("t4_clr_lost", lost,     0);
        check("t4_clr_cnt",  loss_cnt, 0);
        for (int i = 0; i < 257; i++) begin
            lose();
            if (i == 0)   check("t4_cnt_1",   loss_cnt, 1);
            if (i == 254) check("t4_cnt_255", loss_cnt, 255);
            relock();
        end
        check("t4_sat_cnt",  loss_cnt,  255);
        check("t4_sat_lost", lost,      1);
        check("t4_sat_run",  sys_rst_n, 1);
        locked = 1'b0;
        tick();
        tick();
        clear_lost = 1'b1;
        tick();
        clear_lost = 1'b0;
        check("t4_coll_lost", lost,      1);
        check("t4_coll_cnt",  loss_cnt,  1);
        check("t4_coll_sys",  sys_rst_n, 0);
        clear_lost = 1'b1;
        tick();
        clear_lost = 1'b0;
        check("t4_lone_lost", lost,     0);
        check("t4_lone_cnt",  loss_cnt, 0);

        // 5: watchdog with locked held low
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            tick();
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
            exp_pll = ((n >= 20 && n < 25) || (n >= 45 && n < 50));
`else
            exp_pll = 1'b0;
`endif
            check("t5_pll_rst", pll_rst, exp_pll);
        end
        check("t5_sys", sys_rst_n, 0);

        // 6: async reset while in HOLD, then full restart
        relock();
        check("t6_run", sys_rst_n, 1);
        lose();
        check("t6_lost", lost,     1);
        check("t6_cnt",  loss_cnt, 1);
        locked = 1'b1;
        repeat (8) tick();
        check("t6_hold_sys", sys_rst_n, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_sys",  sys_rst_n, 0);
        check("t6_async_rdy",  ready,     0);
        check("t6_async_lost", lost,      0);
        check("t6_async_cnt",  loss_cnt,  0);
        check("t6_async_pll",  pll_rst,   0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("t6_pre_sys", sys_rst_n, 0);
        end
        tick();
        check("t6_run_again", sys_rst_n, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
